// File: rtl/simd_sat_alu.sv
// Two-stage SIMD saturating ALU: full-width and per-lane saturating add/sub plus shifts/rotate.
// S1 holds the accepted operation, S2 holds the computed result; both advance together unless the output is stalled.
module simd_sat_alu #(
    parameter int DATA_W = 16,
    parameter int LANE_W = 4,
    localparam int NLANES = DATA_W / LANE_W,
    localparam int SH_W = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [SH_W-1:0]   shamt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [NLANES-1:0] lane_ovfl,
    output logic [2:0]        flags,
    output logic [7:0]        sat_count
);

    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_PADDSB = 3'b010;
    localparam logic [2:0] OP_PSUBSB = 3'b011;
    localparam logic [2:0] OP_SLL    = 3'b100;
    localparam logic [2:0] OP_SRA    = 3'b101;
    localparam logic [2:0] OP_ROR    = 3'b110;

    // Handshake: a transfer happens on a rising edge where valid & ready are both high;
    // in_ready is low only while a valid result waits for out_ready.
    logic stall;
    logic advance;
    assign stall    = out_valid & ~out_ready;
    assign advance  = ~stall;
    assign in_ready = advance;

    logic              s1_valid;
    logic [2:0]        s1_op;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;
    logic [SH_W-1:0]   s1_shamt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_shamt <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_op    <= op;
            s1_a     <= a;
            s1_b     <= b;
            s1_shamt <= shamt;
        end
    end

    logic              sub_full;
    logic [DATA_W-1:0] b_full;
    logic [DATA_W-1:0] sum_full;
    logic              ovf_full;
    logic [DATA_W-1:0] sat_full;
    logic              sub_lane;
    logic [LANE_W-1:0] la;
    logic [LANE_W-1:0] lb;
    logic [LANE_W-1:0] ls;
    logic              lo;
    logic [DATA_W-1:0] lane_res;
    logic [NLANES-1:0] lane_o;
    logic [SH_W:0]     rot_back;
    logic [DATA_W-1:0] nxt_result;
    logic [NLANES-1:0] nxt_ovfl;
    logic [2:0]        nxt_flags;

    always_comb begin
        sub_full = (s1_op == OP_SUB);
        b_full   = sub_full ? ~s1_b : s1_b;
        sum_full = s1_a + b_full + {{(DATA_W-1){1'b0}}, sub_full};
        ovf_full = (s1_a[DATA_W-1] == b_full[DATA_W-1]) && (sum_full[DATA_W-1] != s1_a[DATA_W-1]);
        sat_full = s1_a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};

        // Each lane is an independent saturating adder; no carry crosses a lane boundary.
        sub_lane = (s1_op == OP_PSUBSB);
        la       = '0;
        lb       = '0;
        ls       = '0;
        lo       = 1'b0;
        lane_res = '0;
        lane_o   = '0;
        for (int i = 0; i < NLANES; i++) begin
            la = s1_a[i*LANE_W +: LANE_W];
            lb = sub_lane ? ~s1_b[i*LANE_W +: LANE_W] : s1_b[i*LANE_W +: LANE_W];
            ls = la + lb + {{(LANE_W-1){1'b0}}, sub_lane};
            lo = (la[LANE_W-1] == lb[LANE_W-1]) && (ls[LANE_W-1] != la[LANE_W-1]);
            if (lo) begin
                ls = la[LANE_W-1] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
            end
            lane_res[i*LANE_W +: LANE_W] = ls;
            lane_o[i] = lo;
        end

        rot_back = (SH_W+1)'(DATA_W) - {1'b0, s1_shamt};

        nxt_result = '0;
        nxt_ovfl   = '0;
        nxt_flags  = flags;
        case (s1_op)
            OP_ADD, OP_SUB: begin
                nxt_result = ovf_full ? sat_full : sum_full;
                nxt_ovfl   = {NLANES{ovf_full}};
                nxt_flags  = {nxt_result[DATA_W-1], ovf_full, nxt_result == '0};
            end
            OP_PADDSB, OP_PSUBSB: begin
                nxt_result = lane_res;
                nxt_ovfl   = lane_o;
                nxt_flags  = {flags[2:1], lane_res == '0};
            end
            OP_SLL, OP_SRA, OP_ROR: begin
                if (s1_op == OP_SLL) begin
                    nxt_result = s1_a << s1_shamt;
                end else if (s1_op == OP_SRA) begin
                    nxt_result = DATA_W'($signed(s1_a) >>> s1_shamt);
                end else begin
                    nxt_result = (s1_a >> s1_shamt) | (s1_a << rot_back);
                end
                nxt_flags = {flags[2:1], nxt_result == '0};
            end
            default: begin
                nxt_result = '0;
                nxt_ovfl   = '0;
                nxt_flags  = flags;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            lane_ovfl <= '0;
            flags     <= '0;
            sat_count <= '0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result    <= nxt_result;
                lane_ovfl <= nxt_ovfl;
                flags     <= nxt_flags;
                if ((|nxt_ovfl) && (sat_count != 8'hFF)) begin
                    sat_count <= sat_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: doc/simd_sat_alu.md
SIMD_SAT_ALU -- requirements
Module: simd_sat_alu

Interface
REQ-001 Parameter DATA_W, default 16, datapath width in bits.
REQ-002 Parameter LANE_W, default 4, partitioned-lane width; DATA_W SHALL be a multiple of LANE_W, and LANE_W SHALL be at least 2.
REQ-003 Derived constants: NLANES = DATA_W/LANE_W; SH_W = clog2(DATA_W).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  operation presented.
REQ-007 in_ready  output  1  operation accepted when in_valid & in_ready at rising edge.
REQ-008 op  input  3  000 ADD, 001 SUB, 010 PADDSB, 011 PSUBSB, 100 SLL, 101 SRA, 110 ROR, 111 reserved.
REQ-009 a, b  input  DATA_W  signed operands; b is unused by shifts.
REQ-010 shamt  input  SH_W  shift/rotate amount.
REQ-011 out_valid  output  1  result registered and valid.
REQ-012 out_ready  input  1  consumer takes result when out_valid & out_ready.
REQ-013 result  output  DATA_W  operation result.
REQ-014 lane_ovfl  output  NLANES  per-lane saturation indicators for the current result; bit 0 is the LSB lane.
REQ-015 flags  output  3  {N,V,Z} register.
REQ-016 sat_count  output  8  count of saturated results.

Function
REQ-017 Two register stages: S1 captures op/a/b/shamt; S2 (the output register) captures the computed result.
REQ-018 stall = out_valid & ~out_ready; in_ready = ~stall; both stages advance together whenever stall is 0.
REQ-019 Latency: an op accepted at edge k SHALL appear with out_valid=1 after edge k+1 when no stall occurs; throughput is one op per cycle.
REQ-020 During stall, S1, S2, result, lane_ovfl, flags and sat_count SHALL hold; no op is lost or duplicated; output order equals acceptance order.
REQ-021 An S1 bubble (no op accepted) SHALL load out_valid=0 into S2 when advancing.
REQ-022 ADD/SUB: full-width two's-complement. Overflow occurs when the operand signs (b inverted for SUB) agree and the result sign differs. On overflow the result SHALL saturate to 0111..1 if a is non-negative, else 1000..0. All lane_ovfl bits are set to the overflow bit.
REQ-023 PADDSB/PSUBSB: NLANES independent LANE_W-bit saturating add/sub; there is no carry between lanes. Each lane saturates per REQ-022 rules on its own bits, and lane_ovfl[i] is set for that lane's overflow.
REQ-024 SLL: logical left shift by shamt. SRA: arithmetic right shift by shamt. ROR: rotate right by shamt. shamt=0 passes a through. Shifts set lane_ovfl=0.
REQ-025 Reserved op: result=0, lane_ovfl=0, flags unchanged, sat_count unchanged.
REQ-026 Flags update only on an S2 load of a valid op. ADD/SUB update N, V and Z. PADDSB/PSUBSB update Z only. Shifts update Z only. Z = (result==0), N = result MSB, V = overflow.
REQ-027 sat_count increments by 1 on each valid S2 load with |lane_ovfl=1 and saturates at 255 (no wrap).

Reset
REQ-028 rst_n low SHALL immediately (asynchronously) clear out_valid, S1 valid, result, lane_ovfl, flags and sat_count to 0, and SHALL force in_ready=1 once out_valid is 0.
REQ-029 Reset mid-operation SHALL discard in-flight ops; the first op accepted after rst_n rises follows REQ-019 latency.

Verification
REQ-030 ADD a=0x7FFF b=0x0001 -> result=0x7FFF, lane_ovfl=4'b1111, flags N=0 V=1 Z=0, sat_count=1.
REQ-031 SUB a=0x8000 b=0x0001 -> result=0x8000, flags N=1 V=1 Z=0.
REQ-032 PADDSB a=0x7981 b=0x1191 -> result=0x7A82, lane_ovfl=4'b1010, sat_count increments by 1.
REQ-033 SRA a=0x8000 shamt=15 -> result=0xFFFF, Z=0. ROR a=0x0001 shamt=1 -> 0x8000. SLL a=0xFFFF shamt=15 -> 0x8000. N/V unchanged for all three.
REQ-034 Backpressure: issue ADD 1+2 and SUB 5-3 back-to-back with out_ready=0 for 3 cycles. in_ready SHALL drop, result SHALL hold 0x0003, and after release the outputs SHALL be 0x0003 then 0x0002 in order.
REQ-035 Assert rst_n=0 while out_valid=1 and sat_count=5 -> out_valid, flags and sat_count SHALL be 0 before the next clock edge. Drive 256 saturating ADDs -> sat_count SHALL stay at 255.
